// File: rtl/uart_rx_unit_pkg.sv
// Shared UART definitions: FSM state encoding, default line settings and
// the divider arithmetic used to turn a baud rate into clock counts.
package uart_rx_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_WAIT_HI = 3'd4
  } uart_state_e;

  localparam int unsigned DEF_CLOCK_HZ  = 50_000_000;
  localparam int unsigned DEF_BAUD_RATE = 115200;

  // Clocks per bit, integer floor.
  function automatic int unsigned uart_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // Clocks from the start edge to the middle of the start bit.
  function automatic int unsigned uart_half(input int unsigned clk_hz,
                                            input int unsigned baud);
    return uart_div(clk_hz, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_unit_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; the reset value is
// a parameter so idle-high lines come out of reset already idle.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ff_q <= {2{RST_VAL}};
    else         ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver: synchronizes rx, samples each bit at its centre,
// checks the stop bit and holds the received byte under valid/ready.
module uart_rx_unit
  import uart_rx_unit_pkg::*;
#(
  parameter int unsigned CLOCK_HZ  = DEF_CLOCK_HZ,
  parameter int unsigned BAUD_RATE = DEF_BAUD_RATE
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned DIV  = uart_div(CLOCK_HZ, BAUD_RATE);
  localparam int unsigned HALF = uart_half(CLOCK_HZ, BAUD_RATE);
  localparam int unsigned CW   = $clog2(DIV);

  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  logic rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .d_i    (rx),
    .q_o    (rx_s)
  );

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          stop_ok, stop_bad, accept;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          // A start bit that is gone by mid-bit was a glitch.
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            stop_ok = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = ST_WAIT_HI;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // A break holds the line low; wait for it to return before rearming.
      ST_WAIT_HI: if (rx_s) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Holding register: a completed byte is loaded only if the slot is free
  // or being drained this same cycle; otherwise it is lost and flagged.
  always_comb begin
    accept  = valid_q & rx_ready;
    valid_d = valid_q & ~accept;
    data_d  = data_q;
    ovr_d   = 1'b0;
    ferr_d  = stop_bad;
    if (stop_ok) begin
      if (!valid_q || accept) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_unit.sv
// Bench for uart_rx_unit: drives serial frames on rx and compares the bytes
// and pulses seen at the output against a frame-level expectation.
`timescale 1ns/1ps
module tb_uart_rx_unit;

  localparam int unsigned CLOCK_HZ  = 50_000_000;
  localparam int unsigned BAUD_RATE = 115200;
  localparam int          DIV       = CLOCK_HZ / BAUD_RATE;
  localparam int          HALF      = DIV / 2;
  localparam int          LAT       = 2 + HALF + 9 * DIV + 1;
  localparam real         BIT_NS    = 1.0e9 / BAUD_RATE;

  logic       clock    = 1'b0;
  logic       reset_n  = 1'b0;
  logic       rx       = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_unit #(.CLOCK_HZ(CLOCK_HZ), .BAUD_RATE(BAUD_RATE)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #10 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Output monitor: every rising rx_valid is a delivered byte.
  logic [7:0] got_q[$];
  int   ferr_cnt = 0, ovr_cnt = 0, both_cnt = 0;
  logic prev_valid = 1'b0;

  always @(negedge clock) begin
    if (rx_valid && !prev_valid) got_q.push_back(rx_data);
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun)   ovr_cnt  <= ovr_cnt + 1;
    if (frame_err && overrun) both_cnt <= both_cnt + 1;
    prev_valid <= rx_valid;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(BIT_NS);
    end
    rx = stop_bit;
    #(BIT_NS);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", rx_valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr got %b exp 0", overrun); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
  endtask

  task automatic test_frame_aa();
    int n0 = got_q.size(), f0 = ferr_cnt, o0 = ovr_cnt;
    int lat = -1;
    @(negedge clock); #3;
    fork
      send_frame(8'hAA, 1'b1);
      begin
        int c = 0;
        while (lat < 0 && c < 5000) begin
          @(negedge clock); c++;
          if (rx_valid) lat = c;
        end
      end
    join
    rx = 1'b1;
    n_checks++; if (lat < LAT - 1 || lat > LAT + 1) begin n_fail++; $display("FAIL aa_latency got %0d exp %0d+/-1", lat, LAT); end
    n_checks++; if (got_q.size() != n0 + 1) begin n_fail++; $display("FAIL aa_count got %0d exp %0d", got_q.size() - n0, 1); end
    else begin
      n_checks++; if (got_q[n0] !== 8'hAA) begin n_fail++; $display("FAIL aa_data got %h exp aa", got_q[n0]); end
    end
    n_checks++; if (ferr_cnt != f0 || ovr_cnt != o0) begin n_fail++; $display("FAIL aa_pulses got ferr %0d ovr %0d exp 0 0", ferr_cnt - f0, ovr_cnt - o0); end
  endtask

  task automatic test_glitch();
    int n0 = got_q.size(), f0 = ferr_cnt;
    int c = 0;
    logic fell = 1'b0;
    @(negedge clock);
    rx = 1'b0;
    repeat (100) @(negedge clock);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_hi got %b exp 1", busy); end
    rx = 1'b1;
    while (!fell && c < HALF + 10) begin
      @(negedge clock); c++;
      if (!busy) fell = 1'b1;
    end
    n_checks++; if (!fell || c > HALF + 1) begin n_fail++; $display("FAIL glitch_busy_fall got %0d cycles exp <= %0d", c, HALF + 1); end
    #(BIT_NS);
    n_checks++; if (got_q.size() != n0 || ferr_cnt != f0) begin n_fail++; $display("FAIL glitch_no_output got bytes %0d ferr %0d exp 0 0", got_q.size() - n0, ferr_cnt - f0); end
  endtask

  task automatic test_frame_err();
    int n0 = got_q.size(), f0 = ferr_cnt, o0 = ovr_cnt;
    send_frame(8'h55, 1'b0);
    #(4 * BIT_NS);
    n_checks++; if (ferr_cnt != f0 + 1) begin n_fail++; $display("FAIL ferr_pulse got %0d exp 1", ferr_cnt - f0); end
    n_checks++; if (got_q.size() != n0) begin n_fail++; $display("FAIL ferr_no_byte got %0d exp 0", got_q.size() - n0); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_held got %b exp 1", busy); end
    rx = 1'b1;
    repeat (5) @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_release got %b exp 0", busy); end
    #(BIT_NS);
    send_frame(8'h3C, 1'b1);
    rx = 1'b1;
    n_checks++; if (got_q.size() != n0 + 1) begin n_fail++; $display("FAIL ferr_next_count got %0d exp 1", got_q.size() - n0); end
    else begin
      n_checks++; if (got_q[n0] !== 8'h3C) begin n_fail++; $display("FAIL ferr_next_data got %h exp 3c", got_q[n0]); end
    end
    n_checks++; if (ferr_cnt != f0 + 1 || ovr_cnt != o0) begin n_fail++; $display("FAIL ferr_total got ferr %0d ovr %0d exp 1 0", ferr_cnt - f0, ovr_cnt - o0); end
  endtask

  task automatic test_overrun();
    int n0 = got_q.size(), f0 = ferr_cnt, o0 = ovr_cnt;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    rx = 1'b1;
    #(BIT_NS);
    send_frame(8'h22, 1'b1);
    rx = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_held got %b exp 1", rx_valid); end
    n_checks++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL ovr_data_kept got %h exp 11", rx_data); end
    n_checks++; if (ovr_cnt != o0 + 1) begin n_fail++; $display("FAIL ovr_pulse got %0d exp 1", ovr_cnt - o0); end
    n_checks++; if (got_q.size() != n0 + 1 || ferr_cnt != f0) begin n_fail++; $display("FAIL ovr_events got bytes %0d ferr %0d exp 1 0", got_q.size() - n0, ferr_cnt - f0); end
    rx_ready = 1'b1;
    @(negedge clock);
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_accept_clear got %b exp 0", rx_valid); end
    n_checks++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL ovr_data_after_accept got %h exp 11", rx_data); end
  endtask

  task automatic test_reset_mid();
    int n0, f0, o0;
    logic [7:0] b = 8'h0F;
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      #(BIT_NS);
    end
    rx = b[4];
    #(BIT_NS / 2);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before got %b exp 1", busy); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data got %h exp 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags got v%b f%b o%b exp 000", rx_valid, frame_err, overrun); end
    rx = 1'b1;
    repeat (5) @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    n0 = got_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'hF0, 1'b1);
    rx = 1'b1;
    n_checks++; if (got_q.size() != n0 + 1) begin n_fail++; $display("FAIL rstmid_count got %0d exp 1", got_q.size() - n0); end
    else begin
      n_checks++; if (got_q[n0] !== 8'hF0) begin n_fail++; $display("FAIL rstmid_data_after got %h exp f0", got_q[n0]); end
    end
    n_checks++; if (ferr_cnt != f0 || ovr_cnt != o0) begin n_fail++; $display("FAIL rstmid_pulses got ferr %0d ovr %0d exp 0 0", ferr_cnt - f0, ovr_cnt - o0); end
  endtask

  task automatic test_back_to_back();
    int n0 = got_q.size(), f0 = ferr_cnt, o0 = ovr_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    rx = 1'b1;
    n_checks++; if (got_q.size() != n0 + 2) begin n_fail++; $display("FAIL b2b_count got %0d exp 2", got_q.size() - n0); end
    else begin
      n_checks++; if (got_q[n0] !== 8'h00 || got_q[n0 + 1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_data got %h %h exp 00 ff", got_q[n0], got_q[n0 + 1]); end
    end
    n_checks++; if (ferr_cnt != f0 || ovr_cnt != o0) begin n_fail++; $display("FAIL b2b_pulses got ferr %0d ovr %0d exp 0 0", ferr_cnt - f0, ovr_cnt - o0); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int exp_ferr = 0;
    int n0 = got_q.size(), f0 = ferr_cnt, o0 = ovr_cnt;
    for (int k = 0; k < 3; k++) begin
      logic [7:0] b = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        send_frame(b, 1'b0);
        #(BIT_NS);
        rx = 1'b1;
        #(BIT_NS);
        exp_ferr++;
      end else begin
        send_frame(b, 1'b1);
        rx = 1'b1;
        exp_q.push_back(b);
      end
      if ($urandom_range(0, 1) == 1) #(BIT_NS);
    end
    repeat (20) @(negedge clock);
    n_checks++; if (got_q.size() - n0 != exp_q.size()) begin n_fail++; $display("FAIL rand_count got %0d exp %0d", got_q.size() - n0, exp_q.size()); end
    else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        n_checks++; if (got_q[n0 + k] !== exp_q[k]) begin n_fail++; $display("FAIL rand_data[%0d] got %h exp %h", k, got_q[n0 + k], exp_q[k]); end
      end
    end
    n_checks++; if (ferr_cnt - f0 != exp_ferr || ovr_cnt != o0) begin n_fail++; $display("FAIL rand_pulses got ferr %0d ovr %0d exp %0d 0", ferr_cnt - f0, ovr_cnt - o0, exp_ferr); end
  endtask

  task automatic test_exclusive();
    n_checks++; if (both_cnt != 0) begin n_fail++; $display("FAIL ferr_ovr_together got %0d exp 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_frame_aa();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
